// File: rtl/stim_pkg.sv
// Shared constants and FSM state type for the stimulus playback controller.
// The GAP state only exists when STIM_PACE_EN is defined.
package stim_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int LOOP_WIDTH_DEF = 8;
  localparam int LAST_ADDR_DEF  = 469;
  localparam int PACE_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef STIM_PACE_EN
    ,
    GAP  = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/stim_playback_ctrl_if.sv
// Sample stream from the playback controller to the FIR input stage.
interface stim_playback_ctrl_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/stim_addr_gen.sv
// ROM address register, period-wrap compare and loop counter.
// Drives the combinational ROM address and flags the final sample to the FSM.
module stim_addr_gen #(
  parameter int ADDR_WIDTH = 9,
  parameter int LOOP_WIDTH = 8,
  parameter int LAST_ADDR  = 469
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [LOOP_WIDTH-1:0] num_loops,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  next_is_last,
  output logic                  is_final
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LOOP_WIDTH-1:0] loop_cnt_reg;
  logic                  at_last;

  assign at_last  = (addr_reg == LAST);
  // loop_cnt of 0 means endless playback, so it can never be final
  assign is_final = at_last && (loop_cnt_reg == LOOP_WIDTH'(1));

  always_comb begin
    addr_next = addr_reg + ADDR_WIDTH'(1);
    if (load || at_last)
      addr_next = '0;
  end

  assign rom_addr     = (load || advance) ? addr_next : addr_reg;
  assign next_is_last = (rom_addr == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg     <= '0;
      loop_cnt_reg <= '0;
    end else if (clear) begin
      addr_reg     <= '0;
      loop_cnt_reg <= '0;
    end else if (load) begin
      addr_reg     <= addr_next;
      loop_cnt_reg <= num_loops;
    end else if (advance) begin
      addr_reg <= addr_next;
      if (at_last && (loop_cnt_reg != '0))
        loop_cnt_reg <= loop_cnt_reg - LOOP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/stim_playback_ctrl.sv
// Plays the stimulus ROM into the FIR input as a valid/ready stream with loop count.
// Define STIM_PACE_EN to add pace_div and the inter-sample GAP state.
module stim_playback_ctrl
  import stim_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOOP_WIDTH = LOOP_WIDTH_DEF,
  parameter int LAST_ADDR  = LAST_ADDR_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LOOP_WIDTH-1:0]   num_loops,
`ifdef STIM_PACE_EN
  input  logic [PACE_WIDTH-1:0]   pace_div,
`endif
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  output logic                    busy,
  output logic                    done,
  stim_playback_ctrl_if.master    out_if
);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic                  busy_reg;
  logic                  done_reg;
`ifdef STIM_PACE_EN
  logic [PACE_WIDTH-1:0] pace_reg;
  logic [PACE_WIDTH-1:0] gap_cnt_reg;
`endif

  logic start_ok;
  logic handshake;
  logic advance;
  logic next_is_last;
  logic is_final;

  assign start_ok  = (state_reg == IDLE) && start && !abort;
  assign handshake = (state_reg == RUN) && out_valid_reg && out_if.out_ready;
  assign advance   = handshake && !abort;

  stim_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LOOP_WIDTH (LOOP_WIDTH),
    .LAST_ADDR  (LAST_ADDR)
  ) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (start_ok),
    .advance      (advance),
    .clear        (abort),
    .num_loops    (num_loops),
    .rom_addr     (rom_addr),
    .next_is_last (next_is_last),
    .is_final     (is_final)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef STIM_PACE_EN
      pace_reg      <= '0;
      gap_cnt_reg   <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg     <= IDLE;
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg     <= RUN;
              out_data_reg  <= rom_data;
              out_valid_reg <= 1'b1;
              out_last_reg  <= next_is_last;
              busy_reg      <= 1'b1;
`ifdef STIM_PACE_EN
              pace_reg      <= pace_div;
`endif
            end
          end
          RUN: begin
            if (handshake) begin
              if (is_final) begin
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
              end else begin
                // next sample is captured now; in paced mode it is held invalid through GAP
                out_data_reg <= rom_data;
                out_last_reg <= next_is_last;
`ifdef STIM_PACE_EN
                if (pace_reg != '0) begin
                  state_reg     <= GAP;
                  out_valid_reg <= 1'b0;
                  gap_cnt_reg   <= pace_reg;
                end
`endif
              end
            end
          end
`ifdef STIM_PACE_EN
          GAP: begin
            if (gap_cnt_reg <= PACE_WIDTH'(1)) begin
              state_reg     <= RUN;
              out_valid_reg <= 1'b1;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - PACE_WIDTH'(1);
            end
          end
`endif
          default: begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_if.out_data  = out_data_reg;
  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_last  = out_last_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;

endmodule

// File: tb/tb_stim_playback_ctrl.sv
// Directed bench for stim_playback_ctrl with a 4-entry ROM (LAST_ADDR=3).
// Define STIM_PACE_EN to also exercise the paced playback sequence.
module tb_stim_playback_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  num_loops;
`ifdef STIM_PACE_EN
  logic [7:0]  pace_div;
`endif
  logic [8:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  stim_playback_ctrl_if #(.DATA_WIDTH(16)) sif ();

  stim_playback_ctrl #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (16),
    .LOOP_WIDTH (8),
    .LAST_ADDR  (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .num_loops (num_loops),
`ifdef STIM_PACE_EN
    .pace_div  (pace_div),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .done      (done),
    .out_if    (sif.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (rom_addr)
      9'd0:    rom_data = 16'd10;
      9'd1:    rom_data = 16'd20;
      9'd2:    rom_data = 16'd30;
      9'd3:    rom_data = 16'd40;
      default: rom_data = 16'hDEAD;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sample(input string tag, input logic [15:0] data, input logic last);
    chk({tag, "_valid"}, 32'(sif.out_valid), 32'd1);
    chk({tag, "_data"},  32'(sif.out_data),  32'(data));
    chk({tag, "_last"},  32'(sif.out_last),  32'(last));
    chk({tag, "_done"},  32'(done),          32'd0);
    $display("sample %s: data=%0d last=%0d", tag, sif.out_data, sif.out_last);
  endtask

  task automatic expect_idle(input string tag, input logic done_exp);
    chk({tag, "_valid"}, 32'(sif.out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_done"},  32'(done),          32'(done_exp));
    $display("idle %s: valid=%0d busy=%0d done=%0d", tag, sif.out_valid, busy, done);
  endtask

  task automatic do_start(input logic [7:0] loops);
    num_loops = loops;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // the address must never leave 0..LAST_ADDR
  always @(negedge clk) begin
    if (reset_n)
      chk("rom_addr_range", 32'(rom_addr <= 9'd3), 32'd1);
  end

  initial begin
    logic [15:0] seq [4];
    seq[0] = 16'd10; seq[1] = 16'd20; seq[2] = 16'd30; seq[3] = 16'd40;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; num_loops = 8'd0;
    sif.out_ready = 1'b1;
`ifdef STIM_PACE_EN
    pace_div = 8'd0;
`endif
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // reset state
    chk("rst_data",  32'(sif.out_data), 32'd0);
    chk("rst_last",  32'(sif.out_last), 32'd0);
    chk("rst_addr",  32'(rom_addr),     32'd0);
    expect_idle("rst", 1'b0);

    // single period, back-to-back
    do_start(8'd1);
    for (int i = 0; i < 4; i++) begin
      expect_sample($sformatf("t1_s%0d", i), seq[i], i == 3);
      tick();
    end
    expect_idle("t1_end", 1'b1);
    tick();
    expect_idle("t1_after", 1'b0);

    // two periods, no bubble at the wrap
    do_start(8'd2);
    for (int i = 0; i < 8; i++) begin
      expect_sample($sformatf("t2_s%0d", i), seq[i % 4], (i % 4) == 3);
      tick();
    end
    expect_idle("t2_end", 1'b1);
    tick();
    expect_idle("t2_after", 1'b0);

    // back-pressure on sample 20
    do_start(8'd1);
    expect_sample("t3_s0", 16'd10, 1'b0);
    tick();
    sif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_sample($sformatf("t3_hold%0d", i), 16'd20, 1'b0);
      tick();
    end
    expect_sample("t3_hold5", 16'd20, 1'b0);
    sif.out_ready = 1'b1;
    tick();
    expect_sample("t3_s2", 16'd30, 1'b0);
    tick();
    expect_sample("t3_s3", 16'd40, 1'b1);
    tick();
    expect_idle("t3_end", 1'b1);
    tick();

    // endless mode, three periods then abort mid-period
    do_start(8'd0);
    for (int i = 0; i < 14; i++) begin
      expect_sample($sformatf("t4_s%0d", i), seq[i % 4], (i % 4) == 3);
      tick();
    end
    expect_sample("t4_pre_abort", 16'd30, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_idle("t4_abort", 1'b0);
    chk("t4_abort_last", 32'(sif.out_last), 32'd0);
    tick();
    expect_idle("t4_abort2", 1'b0);
    do_start(8'd1);
    expect_sample("t4_restart", 16'd10, 1'b0);
    tick(); tick(); tick(); tick();
    expect_idle("t4_restart_end", 1'b1);
    tick();

    // start together with abort is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    expect_idle("t5_both", 1'b0);
    tick();
    expect_idle("t5_both2", 1'b0);

    // start while busy neither restarts nor reloads num_loops
    do_start(8'd1);
    expect_sample("t5_s0", 16'd10, 1'b0);
    tick();
    expect_sample("t5_s1", 16'd20, 1'b0);
    num_loops = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_sample("t5_s2", 16'd30, 1'b0);
    chk("t5_busy", 32'(busy), 32'd1);
    tick();
    expect_sample("t5_s3", 16'd40, 1'b1);
    tick();
    expect_idle("t5_end", 1'b1);
    tick();

    // asynchronous reset mid-playback
    do_start(8'd1);
    tick();
    expect_sample("t7_s1", 16'd20, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(sif.out_valid), 32'd0);
    chk("t7_rst_busy",  32'(busy),          32'd0);
    chk("t7_rst_data",  32'(sif.out_data),  32'd0);
    chk("t7_rst_addr",  32'(rom_addr),      32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    expect_idle("t7_after", 1'b0);

`ifdef STIM_PACE_EN
    // paced playback: two idle cycles after each non-final sample
    pace_div = 8'd2;
    do_start(8'd1);
    pace_div = 8'd0;
    for (int i = 0; i < 4; i++) begin
      expect_sample($sformatf("t6_s%0d", i), seq[i], i == 3);
      tick();
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("t6_gap%0d_%0d_valid", i, g), 32'(sif.out_valid), 32'd0);
          chk($sformatf("t6_gap%0d_%0d_busy", i, g),  32'(busy),          32'd1);
          chk($sformatf("t6_gap%0d_%0d_done", i, g),  32'(done),          32'd0);
          $display("gap t6_%0d_%0d: valid=%0d", i, g, sif.out_valid);
          tick();
        end
      end
    end
    expect_idle("t6_end", 1'b1);
    tick();
    expect_idle("t6_after", 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_playback_ctrl.md
Name: stim_playback_ctrl

Overview:
Sequences playback of the stored sine-wave stimulus ROM into the FIR filter input. Owns the ROM read address and applies a programmable last address and loop count. Presents samples on a valid/ready stream with a last-sample marker. Sits between the stimulus ROM (combinational read) and the FIR input stage.

Parameters:
ADDR_WIDTH, 9, ROM address width.
DATA_WIDTH, 16, sample width.
LOOP_WIDTH, 8, width of the loop-count input.
LAST_ADDR, 469, final ROM address of one waveform period; addresses 0..LAST_ADDR are played.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin playback; honoured only in IDLE.
abort  in  1  stop playback immediately; no done pulse.
num_loops  in  LOOP_WIDTH  periods to play, sampled on accepted start; 0 = play until abort.
rom_addr  out  ADDR_WIDTH  read address to the stimulus ROM.
rom_data  in  DATA_WIDTH  ROM read data, same-cycle (combinational) for rom_addr.
out_data  out  DATA_WIDTH  registered sample to the FIR.
out_valid  out  1  out_data is valid.
out_ready  in  1  FIR accepts the sample.
out_last  out  1  high with out_valid when out_data is from LAST_ADDR.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse after the final sample of the final loop is accepted.

Behaviour:
- Reset: state IDLE, addr_reg=0, loop_cnt=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN, GAP (GAP exists only with the optional feature).
- rom_addr is combinational: addr_next on an accepted start or a handshake (out_valid & out_ready), otherwise addr_reg. out_data registers rom_data at that address. This gives back-to-back throughput of one sample per cycle.
- IDLE: when start=1 and abort=0, load addr_reg=0, loop_cnt=num_loops, out_data=ROM[0], out_valid=1, and go to RUN. out_valid rises on the cycle after start. If start and abort are high together, stay in IDLE.
- RUN: out_valid stays high and out_data/out_last stay stable until the handshake. On a handshake:
  - If addr_reg<LAST_ADDR: addr_reg+1 and load the next sample.
  - If addr_reg==LAST_ADDR and loop_cnt==1: out_valid=0, go to IDLE, done=1 for the next cycle only.
  - If addr_reg==LAST_ADDR otherwise: wrap to addr 0, load ROM[0], and decrement loop_cnt (decrement skipped when loop_cnt==0, i.e. infinite mode).
- out_last = registered (loaded address == LAST_ADDR).
- abort in any state: next cycle IDLE, out_valid=0, out_last=0, done stays 0. addr_reg and loop_cnt are cleared.
- start while busy is ignored. num_loops changes after an accepted start have no effect.
- Address arithmetic stays within ADDR_WIDTH; the comparison against LAST_ADDR is exact, so no address above LAST_ADDR is ever issued.
- A reset mid-playback returns everything to its reset values asynchronously.

Optional Feature:
Macro STIM_PACE_EN.
- Defined: adds input pace_div [7:0], sampled on an accepted start. After each non-final handshake the block enters GAP with out_valid=0 for pace_div cycles, then loads the next sample and returns to RUN. pace_div=0 behaves as undefined-macro.
- Not defined: no pace_div port, no GAP state, back-to-back playback only.
- abort from GAP goes to IDLE.

Decomposition:
- Package stim_pkg: state enum (IDLE/RUN/GAP), default LAST_ADDR, and the width constants.
- One natural sub-module: stim_addr_gen, which holds the address register, wrap compare and loop counter and reports wrap/final indications to the FSM.
- Output registers and the FSM stay in the top module.

Test Plan:
1. LAST_ADDR=3, num_loops=1, out_ready=1, ROM=10,20,30,40 -> out_data 10,20,30,40 on four consecutive cycles; out_last only with 40; done pulses the cycle after; busy low afterward.
2. num_loops=2, out_ready=1 -> sequence 10..40,10..40 with no bubble at the wrap; out_last twice; a single done pulse.
3. out_ready held low 5 cycles on sample 20 -> out_data=20 and out_valid stable throughout; 30 appears on the cycle after ready rises.
4. num_loops=0 for 3 full periods, then abort mid-period -> continuous wrap; out_valid=0 the cycle after abort; done never pulses; a fresh start restarts at 10.
5. start and abort asserted together in IDLE, and start pulsed while busy -> no playback from the first case; no restart or address reset in the second.
6. With STIM_PACE_EN, pace_div=2 -> each sample is followed by 2 cycles of out_valid=0; no gap after the final sample; done timing unchanged relative to the last handshake.
